// File: rtl/fir_pkg.sv
// Shared definitions for the FIR feed side: tap count, sample format,
// sequencer state encoding and the fp16 field constants used by fp2fx.
package fir_pkg;

    localparam int N_TAPS    = 64;
    localparam int SAMP_W    = 16;
    localparam int FRAC_BITS = 8;

    // fp16 layout: 1 sign bit, 5 exponent bits, 10 mantissa bits
    localparam int EXP_BIAS  = 15;
    localparam int MANT_W    = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/fp2fx.sv
// fp2fx: IEEE fp16 to signed Q8.8, purely combinational.
// Truncates toward zero, flushes zero/subnormal inputs to 0, and saturates
// |value| >= 128 as well as inf/NaN to 16'h7FFF / 16'h8001 by sign.
module fp2fx
    import fir_pkg::*;
(
    input  logic [SAMP_W-1:0] fp,
    output logic [SAMP_W-1:0] fx
);

    // Exponent at which the significand LSB weighs exactly one Q8.8 LSB
    localparam logic [4:0] UNITY_EXP = 5'(EXP_BIAS + MANT_W - FRAC_BITS);
    // Smallest exponent whose value reaches 128.0, i.e. beyond Q8.8 range
    localparam logic [4:0] SAT_EXP   = 5'(EXP_BIAS + SAMP_W - FRAC_BITS - 1);

    logic              sign;
    logic [4:0]        expo;
    logic [MANT_W-1:0] mant;
    logic [SAMP_W-1:0] sig;
    logic [SAMP_W-1:0] mag;

    assign sign = fp[SAMP_W-1];
    assign expo = fp[SAMP_W-2 -: 5];
    assign mant = fp[MANT_W-1:0];

    // Shift the implicit-one significand into Q8.8 position, then apply the sign
    always_comb begin
        sig = {{(SAMP_W-MANT_W-1){1'b0}}, 1'b1, mant};
        mag = '0;
        fx  = '0;
        if (expo == 5'd0) begin
            fx = '0;
        end else if (expo >= SAT_EXP) begin
            fx = sign ? 16'h8001 : 16'h7FFF;
        end else begin
            if (expo >= UNITY_EXP) begin
                mag = sig << (expo - UNITY_EXP);
            end else begin
                mag = sig >> (UNITY_EXP - expo);
            end
            fx = sign ? (~mag + 16'd1) : mag;
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: feed side of the N-tap FIR MAC.
// Keeps the last N samples in a circular delay line and N coefficients in a
// flop register file; for each accepted sample it streams N (din, cin) pairs
// followed by one en=0 gap cycle so the MAC can clear its accumulator.
// Define FIR_FP16_IN_EN to accept fp16 samples (converted to Q8.8 by fp2fx).
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int N  = N_TAPS,
    parameter int M  = SAMP_W,
    parameter int CW = $clog2(N)
)
(
    input  logic          clk,
    input  logic          rstn,
    input  logic [M-1:0]  sample_in,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic          coef_we,
    input  logic [CW-1:0] coef_addr,
    input  logic [M-1:0]  coef_wdata,
    output logic          busy,
    output logic          en,
    output logic [CW-1:0] cnt,
    output logic [M-1:0]  din,
    output logic [M-1:0]  cin,
    output logic          frame_done
);

    state_t        state;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] base;
    logic [CW-1:0] next_cnt;
    logic [M-1:0]  sample_q;
    logic [M-1:0]  delay_line [N];
    logic [M-1:0]  coef       [N];

`ifdef FIR_FP16_IN_EN
    fp2fx u_fp2fx (
        .fp (sample_in),
        .fx (sample_q)
    );
`else
    assign sample_q = sample_in;
`endif

    assign sample_ready = (state == IDLE);
    assign busy         = (state != IDLE);
    assign next_cnt     = cnt + 1'b1;

    // Sequencer FSM with registered MAC-side outputs, delay line and coefficient file
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            base       <= '0;
            en         <= 1'b0;
            cnt        <= '0;
            din        <= '0;
            cin        <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < N; i++) begin
                delay_line[i] <= '0;
                coef[i]       <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (coef_we) begin
                        coef[coef_addr] <= coef_wdata;
                    end
                    if (sample_valid) begin
                        delay_line[wr_ptr] <= sample_q;
                        wr_ptr <= wr_ptr + 1'b1;
                        base   <= wr_ptr;
                        state  <= RUN;
                        en     <= 1'b1;
                        cnt    <= '0;
                        din    <= sample_q;
                        cin    <= (coef_we && (coef_addr == '0)) ? coef_wdata : coef[0];
                    end
                end
                RUN: begin
                    if (cnt == CW'(N-1)) begin
                        state      <= GAP;
                        en         <= 1'b0;
                        cnt        <= '0;
                        din        <= '0;
                        cin        <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        cnt <= next_cnt;
                        din <= delay_line[base - next_cnt];
                        cin <= coef[next_cnt];
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer. A bench-side model of the delay
// line and coefficient file pushes the expected 64 pairs plus the gap cycle
// into a queue at every accept; a monitor pops and compares on every output.
// Build with FIR_FP16_IN_EN defined to exercise the fp16 input path.
module tb_fir_tap_sequencer;

    logic        clk;
    logic        rstn;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        coef_we;
    logic [5:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic        busy;
    logic        en;
    logic [5:0]  cnt;
    logic [15:0] din;
    logic [15:0] cin;
    logic        frame_done;

`ifdef FIR_FP16_IN_EN
    localparam logic [15:0] ONE   = 16'h3C00;
    localparam logic [15:0] THREE = 16'h4200;
    localparam logic [15:0] SEVEN = 16'h4700;
`else
    localparam logic [15:0] ONE   = 16'h0100;
    localparam logic [15:0] THREE = 16'h0300;
    localparam logic [15:0] SEVEN = 16'h0700;
`endif

    typedef struct {
        logic        en;
        logic [5:0]  cnt;
        logic [15:0] din;
        logic [15:0] cin;
        logic        fd;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [15:0] m_hist [64];
    logic [15:0] m_coef [64];
    int          m_wp;
    int          n_vec;
    int          n_err;
    int          mac_acc;
    int          mac_last;
    int          fd_count;

    fir_tap_sequencer dut (
        .clk          (clk),
        .rstn         (rstn),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_wdata   (coef_wdata),
        .busy         (busy),
        .en           (en),
        .cnt          (cnt),
        .din          (din),
        .cin          (cin),
        .frame_done   (frame_done)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference conversion of an input word to the Q8.8 value the MAC should see
    function automatic logic [15:0] conv(input logic [15:0] s);
`ifdef FIR_FP16_IN_EN
        int  e;
        int  q;
        real v;
        e = int'(s[14:10]);
        if (e == 0) return 16'h0000;
        if (e == 31) return s[15] ? 16'h8001 : 16'h7FFF;
        v = (1.0 + real'(s[9:0]) / 1024.0) * (2.0 ** (e - 15));
        if (v >= 128.0) return s[15] ? 16'h8001 : 16'h7FFF;
        q = $rtoi(v * 256.0);
        if (s[15]) q = -q;
        return 16'(q);
`else
        return s;
`endif
    endfunction

    // Reset clears both arrays and the write pointer in the model
    function automatic void reset_model();
        for (int i = 0; i < 64; i++) begin
            m_hist[i] = '0;
            m_coef[i] = '0;
        end
        m_wp = 0;
        exp_q.delete();
        mac_acc = 0;
    endfunction

    // Record an accepted sample and queue the burst plus gap cycle it must produce
    function automatic void push_burst(input logic [15:0] s);
        exp_t e;
        int   base;
        m_hist[m_wp] = conv(s);
        base = m_wp;
        m_wp = (m_wp + 1) % 64;
        for (int k = 0; k < 64; k++) begin
            e.en  = 1'b1;
            e.cnt = 6'(k);
            e.din = m_hist[(base - k + 64) % 64];
            e.cin = m_coef[k];
            e.fd  = 1'b0;
            exp_q.push_back(e);
        end
        e.en  = 1'b0;
        e.cnt = '0;
        e.din = '0;
        e.cin = '0;
        e.fd  = 1'b1;
        exp_q.push_back(e);
    endfunction

    // Scoreboard monitor: every en or frame_done cycle must match the queue head,
    // and a non-empty queue means the DUT must be producing output this cycle
    always @(negedge clk) begin
        if (en === 1'b1 || frame_done === 1'b1) begin
            if (en === 1'b1) mac_acc += $signed(din) * $signed(cin);
            if (frame_done === 1'b1) begin
                mac_last = mac_acc;
                mac_acc  = 0;
                fd_count++;
            end
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("[TB] FAIL unexpected_output: got en=%0b fd=%0b cnt=%0d din=%h, expected no output",
                         en, frame_done, cnt, din);
            end else begin
                mon_e = exp_q.pop_front();
                if ({en, cnt, din, cin, frame_done} !== {mon_e.en, mon_e.cnt, mon_e.din, mon_e.cin, mon_e.fd}) begin
                    n_err++;
                    $display("[TB] FAIL pair: got en=%0b cnt=%0d din=%h cin=%h fd=%0b, expected en=%0b cnt=%0d din=%h cin=%h fd=%0b",
                             en, cnt, din, cin, frame_done, mon_e.en, mon_e.cnt, mon_e.din, mon_e.cin, mon_e.fd);
                end
            end
        end else if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL stall: got en=%b fd=%b, expected cnt=%0d en=%0b fd=%0b",
                     en, frame_done, exp_q[0].cnt, exp_q[0].en, exp_q[0].fd);
            exp_q.delete();
        end
    end

    // Accept one sample in IDLE, optionally with a coefficient write in the same cycle
    task automatic accept_sample(input logic [15:0] s, input logic we,
                                 input logic [5:0] addr, input logic [15:0] data);
        @(negedge clk);
        sample_in    = s;
        sample_valid = 1'b1;
        coef_we      = we;
        coef_addr    = addr;
        coef_wdata   = data;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        coef_we      = 1'b0;
        if (we) m_coef[addr] = data;
        push_burst(s);
    endtask

    // Coefficient write while the sequencer is idle
    task automatic write_coef(input logic [5:0] addr, input logic [15:0] data);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = addr;
        coef_wdata = data;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        m_coef[addr] = data;
    endtask

    // Wait (bounded) for the queued burst to finish and the FSM to return to IDLE
    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL drain_timeout: got %0d pending outputs, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_model();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({en, cnt, din, cin, frame_done, busy} !== 36'd0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got en=%b cnt=%h din=%h cin=%h fd=%b busy=%b, expected all 0",
                     en, cnt, din, cin, frame_done, busy);
        end
        reset_model();
        rstn = 1'b1;
        @(negedge clk);
        n_vec++;
        if (sample_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_ready: got ready=%b busy=%b, expected ready=1 busy=0", sample_ready, busy);
        end
    endtask

    task automatic test_single();
        int fd_before;
        write_coef(6'd0, 16'h0100);
        fd_before = fd_count;
        @(negedge clk);
        n_vec++;
        if (sample_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL single_ready: got %b, expected 1", sample_ready);
        end
        accept_sample(ONE, 1'b0, 6'd0, 16'h0000);
        drain();
        n_vec++;
        if (mac_last !== 32'h0001_0000) begin
            n_err++;
            $display("[TB] FAIL single_mac: got %h, expected 00010000", mac_last);
        end
        n_vec++;
        if (fd_count !== fd_before + 1) begin
            n_err++;
            $display("[TB] FAIL single_frame_done: got %0d pulses, expected 1", fd_count - fd_before);
        end
    endtask

    task automatic test_impulse();
        do_reset();
        for (int k = 0; k < 64; k++) write_coef(6'(k), 16'(k + 1));
        for (int j = 0; j < 64; j++) begin
            accept_sample((j == 0) ? ONE : 16'h0000, 1'b0, 6'd0, 16'h0000);
            drain();
        end
        accept_sample(THREE, 1'b0, 6'd0, 16'h0000);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [15:0] s [3];
        int gaps;
        s[0] = 16'h0011;
        s[1] = 16'h0022;
        s[2] = 16'h0033;
        @(negedge clk);
        sample_in    = s[0];
        sample_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            n_vec++;
            if (sample_ready !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL b2b_accept_ready: burst %0d got %b, expected 1", b, sample_ready);
            end
            @(posedge clk);
            #1;
            push_burst(s[b]);
            if (b == 2) sample_valid = 1'b0;
            else sample_in = s[b + 1];
            gaps = 0;
            for (int c = 1; c <= 65; c++) begin
                @(negedge clk);
                n_vec++;
                if (sample_ready !== 1'b0 || busy !== 1'b1) begin
                    n_err++;
                    $display("[TB] FAIL b2b_holdoff: cycle %0d got ready=%b busy=%b, expected ready=0 busy=1",
                             c, sample_ready, busy);
                end
                if (en !== 1'b1) gaps++;
            end
            n_vec++;
            if (gaps !== 1) begin
                n_err++;
                $display("[TB] FAIL b2b_gap: got %0d en=0 busy cycles, expected 1", gaps);
            end
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_coef_guard();
        accept_sample(ONE, 1'b0, 6'd0, 16'h0000);
        repeat (10) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL guard_busy: got %b, expected 1", busy);
        end
        coef_we    = 1'b1;
        coef_addr  = 6'd5;
        coef_wdata = 16'h7FFF;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        drain();
        accept_sample(THREE, 1'b1, 6'd5, 16'h7FFF);
        drain();
        accept_sample(ONE, 1'b1, 6'd0, 16'h1234);
        drain();
    endtask

    task automatic test_reset_midburst();
        int fd_before;
        accept_sample(THREE, 1'b0, 6'd0, 16'h0000);
        repeat (31) @(negedge clk);
        n_vec++;
        if (cnt !== 6'd30) begin
            n_err++;
            $display("[TB] FAIL abort_point: got cnt=%0d, expected 30", cnt);
        end
        rstn = 1'b0;
        @(posedge clk);
        #1;
        reset_model();
        fd_before = fd_count;
        @(negedge clk);
        n_vec++;
        if (en !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_outputs: got en=%b fd=%b busy=%b, expected 0 0 0", en, frame_done, busy);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (70) @(negedge clk);
        n_vec++;
        if (fd_count !== fd_before) begin
            n_err++;
            $display("[TB] FAIL abort_frame_done: got %0d pulses, expected 0", fd_count - fd_before);
        end
        write_coef(6'd0, 16'h0100);
        accept_sample(SEVEN, 1'b0, 6'd0, 16'h0000);
        drain();
    endtask

`ifdef FIR_FP16_IN_EN
    task automatic test_fp16();
        logic [15:0] fp_in [5];
        logic [15:0] q_out [5];
        fp_in[0] = 16'h3C00; q_out[0] = 16'h0100;
        fp_in[1] = 16'hC000; q_out[1] = 16'hFE00;
        fp_in[2] = 16'h7C00; q_out[2] = 16'h7FFF;
        fp_in[3] = 16'h5800; q_out[3] = 16'h7FFF;
        fp_in[4] = 16'h0001; q_out[4] = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            accept_sample(fp_in[i], 1'b0, 6'd0, 16'h0000);
            @(negedge clk);
            n_vec++;
            if (din !== q_out[i]) begin
                n_err++;
                $display("[TB] FAIL fp16_convert: in %h got din=%h, expected %h", fp_in[i], din, q_out[i]);
            end
            drain();
        end
    endtask
`endif

    // Scenario sequence
    initial begin
        n_vec        = 0;
        n_err        = 0;
        mac_acc      = 0;
        mac_last     = 0;
        fd_count     = 0;
        rstn         = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        coef_we      = 1'b0;
        coef_addr    = '0;
        coef_wdata   = '0;
        reset_model();
        test_reset();
        test_single();
        test_impulse();
        test_back_to_back();
        test_coef_guard();
        test_reset_midburst();
`ifdef FIR_FP16_IN_EN
        test_fp16();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
